// File: rtl/snake_body_arbiter.sv
// Snake body store and single-port RAM arbiter.
// The body lives in an external 1-cycle-latency RAM as a circular buffer
// (logical index k at address HeadPtr+k). Each step writes a new head and
// then scans the rest of the body for a self-collision. Meanwhile a VGA
// reader shares the RAM port through a fixed-priority arbiter that has a
// starvation guard for the scan.
module snake_body_arbiter #(
    parameter int NUM_PIECES   = 32,
    parameter int YBITS        = 5,
    parameter int XBITS        = 6,
    parameter int STARVE_LIMIT = 4,
    localparam int AW          = $clog2(NUM_PIECES),
    localparam int LW          = AW + 1,
    localparam int DW          = YBITS + XBITS,
    localparam int SW          = $clog2(STARVE_LIMIT + 2)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_init_valid,
    input  logic             i_step_valid,
    output logic             o_step_ready,
    input  logic [YBITS-1:0] i_step_y,
    input  logic [XBITS-1:0] i_step_x,
    input  logic             i_step_grow,
    output logic             o_step_done,
    output logic             o_step_hit,
    output logic [LW-1:0]    o_length,
    input  logic             i_vga_req,
    input  logic [AW-1:0]    i_vga_index,
    output logic             o_vga_gnt,
    output logic             o_vga_valid,
    output logic [YBITS-1:0] o_vga_y,
    output logic [XBITS-1:0] o_vga_x,
    output logic [AW-1:0]    o_mem_addr,
    output logic             o_mem_we,
    output logic [DW-1:0]    o_mem_wdata,
    input  logic [DW-1:0]    i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WRITE_HEAD = 2'd1,
        S_SCAN       = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    state_t             r_state;
    logic [AW-1:0]      r_head_ptr;
    logic [LW-1:0]      r_length;
    logic [YBITS-1:0]   r_lat_y;
    logic [XBITS-1:0]   r_lat_x;
    logic               r_lat_grow;
    logic               r_hit;
    logic [SW-1:0]      r_starve_cnt;
    logic [LW-1:0]      r_scan_idx;   // next logical index the scan will read
    logic               r_cmp_pend;   // scan read issued last cycle, data on i_mem_rdata now
    logic               r_vga_pend;   // VGA read issued last cycle
    logic               r_vga_oob;    // that VGA read was past the tail

    logic               w_init;
    logic               w_wh;
    logic               w_scan_pend;
    logic               w_starved;
    logic               w_vga_gnt;
    logic               w_scan_gnt;
    logic               w_vga_oob;
    logic [AW-1:0]      w_new_head;
    logic [LW-1:0]      w_len_next;
    logic               w_step_done;
    logic [AW-1:0]      w_mem_addr;
    logic               w_mem_we;
    logic [DW-1:0]      w_mem_wdata;

    // Port users, highest priority first: init write, head write, VGA, scan.
    // Everything is gated by reset so the RAM port is quiet while held.
    assign w_init      = i_rst_n & i_init_valid;
    assign w_wh        = i_rst_n & ~i_init_valid & (r_state == S_WRITE_HEAD);
    assign w_scan_pend = (r_state == S_SCAN) & (r_scan_idx < r_length);
    assign w_starved   = (r_starve_cnt >= SW'(STARVE_LIMIT));
    assign w_vga_gnt   = i_rst_n & i_vga_req & ~i_init_valid
                       & (r_state != S_WRITE_HEAD)
                       & ~(w_scan_pend & w_starved);
    assign w_scan_gnt  = i_rst_n & w_scan_pend & ~i_init_valid & ~w_vga_gnt;

    // Out-of-range VGA reads still touch the RAM; the result is zeroed later.
    assign w_vga_oob   = ({1'b0, i_vga_index} >= r_length);
    assign w_new_head  = r_head_ptr - 1'b1;
    assign w_len_next  = (r_lat_grow && (r_length < LW'(NUM_PIECES)))
                       ? r_length + 1'b1 : r_length;

    // RAM port mux driven by the arbitration result.
    always_comb begin
        w_mem_addr  = '0;
        w_mem_we    = 1'b0;
        w_mem_wdata = '0;
        if (w_init) begin
            w_mem_we    = 1'b1;
            w_mem_wdata = {i_step_y, i_step_x};
        end else if (w_wh) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = w_new_head;
            w_mem_wdata = {r_lat_y, r_lat_x};
        end else if (w_vga_gnt) begin
            w_mem_addr  = r_head_ptr + i_vga_index;
        end else if (w_scan_gnt) begin
            w_mem_addr  = r_head_ptr + r_scan_idx[AW-1:0];
        end
    end

    // Step FSM, body pointers, hit flag, starvation counter and VGA tracking.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_head_ptr   <= '0;
            r_length     <= LW'(1);
            r_lat_y      <= '0;
            r_lat_x      <= '0;
            r_lat_grow   <= 1'b0;
            r_hit        <= 1'b0;
            r_starve_cnt <= '0;
            r_scan_idx   <= '0;
            r_cmp_pend   <= 1'b0;
            r_vga_pend   <= 1'b0;
            r_vga_oob    <= 1'b0;
        end else if (i_init_valid) begin
            // Init wins everywhere: drop any in-flight step and VGA result.
            r_state      <= S_IDLE;
            r_head_ptr   <= '0;
            r_length     <= LW'(1);
            r_hit        <= 1'b0;
            r_starve_cnt <= '0;
            r_scan_idx   <= '0;
            r_cmp_pend   <= 1'b0;
            r_vga_pend   <= 1'b0;
            r_vga_oob    <= 1'b0;
        end else begin
            r_vga_pend <= w_vga_gnt;
            r_vga_oob  <= w_vga_oob;
            r_cmp_pend <= w_scan_gnt;

            // Count back-to-back VGA wins that held off a pending scan read.
            if (w_scan_gnt || (r_state != S_SCAN))
                r_starve_cnt <= '0;
            else if (w_vga_gnt && w_scan_pend)
                r_starve_cnt <= r_starve_cnt + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (i_step_valid) begin
                        r_lat_y    <= i_step_y;
                        r_lat_x    <= i_step_x;
                        r_lat_grow <= i_step_grow;
                        r_hit      <= 1'b0;
                        r_state    <= S_WRITE_HEAD;
                    end
                end
                S_WRITE_HEAD: begin
                    // Head moves back one slot; not growing leaves the old
                    // tail outside the window, which drops it.
                    r_head_ptr <= w_new_head;
                    r_length   <= w_len_next;
                    r_scan_idx <= LW'(1);
                    r_state    <= (w_len_next == LW'(1)) ? S_DONE : S_SCAN;
                end
                S_SCAN: begin
                    if (w_scan_gnt)
                        r_scan_idx <= r_scan_idx + 1'b1;
                    if (r_cmp_pend && (i_mem_rdata == {r_lat_y, r_lat_x}))
                        r_hit <= 1'b1;
                    // Last read's data is compared this cycle; no early exit.
                    if (r_cmp_pend && !w_scan_pend)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_hit   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_step_done  = (r_state == S_DONE) & ~i_init_valid;

    assign o_step_ready = (r_state == S_IDLE) & ~i_init_valid;
    assign o_step_done  = w_step_done;
    assign o_step_hit   = w_step_done & r_hit;
    assign o_length     = r_length;
    assign o_vga_gnt    = w_vga_gnt;
    assign o_vga_valid  = r_vga_pend;
    assign o_vga_y      = (r_vga_pend && !r_vga_oob) ? i_mem_rdata[DW-1:XBITS] : '0;
    assign o_vga_x      = (r_vga_pend && !r_vga_oob) ? i_mem_rdata[XBITS-1:0]  : '0;
    assign o_mem_addr   = w_mem_addr;
    assign o_mem_we     = w_mem_we;
    assign o_mem_wdata  = w_mem_wdata;

endmodule

// File: tb/tb_snake_body_arbiter.sv
// Scoreboard bench for snake_body_arbiter: the driver updates a queue-based
// body model and pushes expected StepDone/VGA results; a negedge monitor
// pops and compares whenever the DUT presents them.
module tb_snake_body_arbiter;
    localparam int NP = 32, YB = 5, XB = 6, SL = 4;
    localparam int AW = 5, LW = 6, DW = YB + XB;

    typedef struct packed { logic [YB-1:0] y; logic [XB-1:0] x; } pc_t;
    typedef struct { logic hit; int due; } done_t;

    logic clk = 0, rst_n = 0;
    logic init_valid = 0, step_valid = 0, step_grow = 0, vga_req = 0;
    logic [YB-1:0] step_y = '0;
    logic [XB-1:0] step_x = '0;
    logic [AW-1:0] vga_index = '0;
    logic step_ready, step_done, step_hit, vga_gnt, vga_valid, mem_we;
    logic [LW-1:0] length;
    logic [YB-1:0] vga_y;
    logic [XB-1:0] vga_x;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    snake_body_arbiter #(.NUM_PIECES(NP), .YBITS(YB), .XBITS(XB), .STARVE_LIMIT(SL)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_init_valid(init_valid),
        .i_step_valid(step_valid), .o_step_ready(step_ready),
        .i_step_y(step_y), .i_step_x(step_x), .i_step_grow(step_grow),
        .o_step_done(step_done), .o_step_hit(step_hit), .o_length(length),
        .i_vga_req(vga_req), .i_vga_index(vga_index), .o_vga_gnt(vga_gnt),
        .o_vga_valid(vga_valid), .o_vga_y(vga_y), .o_vga_x(vga_x),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata));

    always #5 clk = ~clk;

    // External RAM, one-cycle read latency, plus write tracking.
    logic [DW-1:0] ram [NP];
    int we_cnt = 0;
    logic [AW-1:0] we_addr = '0;
    int cyc = 0;
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_cnt  <= we_cnt + 1;
            we_addr <= mem_addr;
        end
        mem_rdata <= ram[mem_addr];
        cyc <= cyc + 1;
    end

    // Reference model: body as a queue, head first; hp = address of the head.
    pc_t   body[$];
    int    hp = 0;
    done_t done_q[$];
    pc_t   vga_q[$];
    int    n_chk = 0, n_pass = 0, done_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic pc_t model_read(input int idx);
        if (idx < body.size()) return body[idx];
        return '0;
    endfunction

    task automatic model_step(input logic [YB-1:0] y, input logic [XB-1:0] x,
                              input logic grow, output logic hit);
        pc_t p;
        p.y = y; p.x = x;
        body.push_front(p);
        if (!grow || body.size() > NP) void'(body.pop_back());
        hp = (hp + NP - 1) % NP;
        hit = 0;
        for (int i = 1; i < body.size(); i++) if (body[i] == p) hit = 1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a result.
    done_t md;
    pc_t   mv;
    always @(negedge clk) begin
        if (rst_n) begin
            if (step_done) begin
                done_seen++;
                if (done_q.size() == 0) chk("unexpected_step_done", step_done, 0);
                else begin
                    md = done_q.pop_front();
                    chk("step_hit", step_hit, md.hit);
                    chk("step_done_cycle", cyc, md.due);
                end
            end
            if (vga_valid) begin
                if (vga_q.size() == 0) chk("unexpected_vga_valid", vga_valid, 0);
                else begin
                    mv = vga_q.pop_front();
                    chk("vga_data", {vga_y, vga_x}, mv);
                end
            end
        end
    end

    task automatic do_init(input logic [YB-1:0] y, input logic [XB-1:0] x);
        pc_t p;
        @(posedge clk); #1;
        init_valid = 1; step_y = y; step_x = x;
        @(negedge clk);
        done_q.delete();
        body.delete();
        p.y = y; p.x = x;
        body.push_back(p);
        hp = 0;
        @(posedge clk); #1;
        init_valid = 0;
        @(negedge clk);
        chk("init_length", length, 1);
        chk("init_ready", step_ready, 1);
    endtask

    // Issue a step; returns the accept cycle and write count at accept.
    task automatic start_step(input logic [YB-1:0] y, input logic [XB-1:0] x,
                              input logic grow, input logic vga_hold, output int we0);
        logic hit;
        int L, due;
        @(posedge clk); #1;
        step_valid = 1; step_y = y; step_x = x; step_grow = grow;
        @(negedge clk);
        chk("step_ready", step_ready, 1);
        we0 = we_cnt;
        model_step(y, x, grow, hit);
        L = body.size();
        if (vga_hold) due = cyc + 3 + 5 * (L - 1);
        else          due = cyc + ((L == 1) ? 2 : L + 2);
        done_q.push_back('{hit, due});
        @(posedge clk); #1;
        step_valid = 0;
    endtask

    task automatic finish_step(input int we0);
        int b = 0;
        while (done_q.size() != 0 && b < 200) begin
            @(negedge clk); #1;
            b++;
        end
        chk("step_done_seen", done_q.size(), 0);
        done_q.delete();
        chk("head_writes", we_cnt - we0, 1);
        chk("head_addr", we_addr, hp);
        chk("length", length, body.size());
    endtask

    task automatic do_step(input logic [YB-1:0] y, input logic [XB-1:0] x, input logic grow);
        int we0;
        start_step(y, x, grow, 1'b0, we0);
        finish_step(we0);
    endtask

    task automatic do_vga(input int idx);
        @(posedge clk); #1;
        vga_req = 1; vga_index = AW'(idx);
        @(negedge clk);
        chk("vga_gnt_idle", vga_gnt, 1);
        if (vga_gnt) vga_q.push_back(model_read(idx));
        @(posedge clk); #1;
        vga_req = 0;
        @(negedge clk);
    endtask

    initial begin
        int we0, r, ds;
        logic eg;

        // Reset values, including gating of requests while reset is held.
        #12;
        chk("rst_ready", step_ready, 1);
        chk("rst_length", length, 1);
        chk("rst_done", step_done, 0);
        chk("rst_vga_valid", vga_valid, 0);
        chk("rst_vga_yx", {vga_y, vga_x}, 0);
        chk("rst_mem", {mem_we, mem_addr, mem_wdata}, 0);
        vga_req = 1; init_valid = 1; #1;
        chk("rst_vga_gnt", vga_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        vga_req = 0; init_valid = 0;
        @(posedge clk); #1; rst_n = 1;

        // Single-piece step: one head write at NP-1, done two cycles on.
        do_init(5'd3, 6'd6);
        do_step(5'd3, 6'd7, 1'b0);
        do_vga(0);
        do_vga(1);   // index == Length -> zeros

        // Straight line to 4 pieces, then back onto piece 2 -> hit.
        do_init(5'd5, 6'd5);
        do_step(5'd5, 6'd6, 1'b1);
        do_step(5'd5, 6'd7, 1'b1);
        do_step(5'd5, 6'd8, 1'b1);
        do_step(5'd5, 6'd6, 1'b0);
        do_vga(4);   // index == Length -> zeros
        do_vga(3);

        // VGA held across a 4-piece scan: every 5th scan cycle goes to the scan.
        do_init(5'd1, 6'd1);
        do_step(5'd1, 6'd2, 1'b1);
        do_step(5'd1, 6'd3, 1'b1);
        do_step(5'd1, 6'd4, 1'b1);
        start_step(5'd1, 6'd5, 1'b0, 1'b1, we0);
        r = body.size() - 1;
        vga_req = 1;
        for (int k = 1; k <= 5 * r + 3; k++) begin
            vga_index = AW'($urandom_range(0, 5));
            @(negedge clk);
            if (k == 1)           eg = 0;
            else if (k >= 5*r+2)  eg = 1;
            else                  eg = ((k - 1) % 5) != 0;
            chk("starve_gnt", vga_gnt, eg);
            if (vga_gnt) vga_q.push_back(model_read(int'(vga_index)));
            @(posedge clk); #1;
        end
        vga_req = 0;
        finish_step(we0);

        // Randomized mix on a small grid so collisions happen often.
        do_init(5'd0, 6'd0);
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: do_step(YB'($urandom_range(0, 3)), XB'($urandom_range(0, 3)),
                                 1'($urandom_range(0, 1)));
                3, 4:    do_vga($urandom_range(0, NP - 1));
                default: do_init(YB'($urandom_range(0, 3)), XB'($urandom_range(0, 3)));
            endcase
        end

        // 40 growth steps: length saturates, pointer wraps, full readback.
        do_init(YB'($urandom), XB'($urandom));
        for (int i = 0; i < 40; i++) do_step(YB'($urandom), XB'($urandom), 1'b1);
        chk("saturated_length", length, NP);
        for (int i = 0; i < NP; i++) do_vga(i);

        // Init mid-scan: no StepDone, back to one piece and ready.
        do_step(5'd2, 6'd2, 1'b1);
        start_step(5'd2, 6'd3, 1'b1, 1'b0, we0);
        @(posedge clk); #1;
        ds = done_seen;
        do_init(5'd9, 6'd9);
        repeat (40) @(negedge clk);
        chk("no_done_after_init", done_seen, ds);
        do_vga(0);

        // Reset mid-scan: same outcome.
        for (int i = 0; i < 4; i++) do_step(5'd9, XB'(10 + i), 1'b1);
        start_step(5'd9, 6'd20, 1'b1, 1'b0, we0);
        @(posedge clk); #1;
        ds = done_seen;
        rst_n = 0; #1;
        chk("midrst_ready", step_ready, 1);
        chk("midrst_length", length, 1);
        chk("midrst_done", step_done, 0);
        chk("midrst_mem_we", mem_we, 0);
        done_q.delete();
        vga_q.delete();
        @(posedge clk); #1; rst_n = 1;
        @(negedge clk);
        chk("post_rst_ready", step_ready, 1);
        repeat (40) @(negedge clk);
        chk("no_done_after_reset", done_seen, ds);
        do_init(5'd4, 6'd4);
        do_step(5'd4, 6'd5, 1'b0);
        do_vga(0);

        repeat (3) @(negedge clk);
        chk("vga_queue_drained", vga_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/snake_body_arbiter.md
SNAKE_BODY_ARBITER -- requirements
Module: snake_body_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PIECES, default 32, the body-store depth (power of two, >=2).
REQ-002 The block SHALL have parameter YBITS, default 5, the width of a y-coordinate.
REQ-003 The block SHALL have parameter XBITS, default 6, the width of an x-coordinate.
REQ-004 The block SHALL have parameter STARVE_LIMIT, default 4, the maximum number of consecutive VGA grants while a scan is waiting.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
- Clock  in  1  rising-edge clock.
- ResetN  in  1  asynchronous active-low reset.
- InitValid  in  1  load a one-piece snake at StepY/StepX.
- StepValid  in  1  step request.
- StepReady  out  1  step accepted when high with StepValid.
- StepY  in  YBITS  new head y.
- StepX  in  XBITS  new head x.
- StepGrow  in  1  keep the tail on this step.
- StepDone  out  1  one-cycle step-complete pulse.
- StepHit  out  1  self-collision result, valid with StepDone.
- Length  out  log2(NUM_PIECES)+1  current piece count.
- VgaReq  in  1  VGA read request.
- VgaIndex  in  log2(NUM_PIECES)  logical piece index, 0 = head.
- VgaGnt  out  1  VGA request granted this cycle.
- VgaValid  out  1  VgaY/VgaX valid.
- VgaY  out  YBITS  piece y.
- VgaX  out  XBITS  piece x.
- MemAddr  out  log2(NUM_PIECES)  single-port RAM address.
- MemWe  out  1  RAM write enable.
- MemWData  out  YBITS+XBITS  write data, {y,x}.
- MemRData  in  YBITS+XBITS  read data, one-cycle latency.

Function
REQ-006 The body SHALL be stored as a circular buffer: logical index k SHALL map to address (HeadPtr+k) mod NUM_PIECES.
REQ-007 The FSM SHALL have four states: IDLE, WRITE_HEAD, SCAN and DONE.
REQ-008 StepReady SHALL be high only in IDLE with InitValid low; StepValid&&StepReady SHALL latch StepY, StepX and StepGrow, then move to WRITE_HEAD.
REQ-009 WRITE_HEAD SHALL do the following:
- Decrement HeadPtr mod NUM_PIECES.
- Write the latched {y,x} at the new HeadPtr (MemWe=1 for exactly one cycle).
- Increment Length only if StepGrow=1 and Length<NUM_PIECES; otherwise hold Length, so the tail drops implicitly.
REQ-010 If the post-step Length equals 1, WRITE_HEAD SHALL go to DONE with StepHit=0; otherwise it SHALL go to SCAN.
REQ-011 SCAN SHALL read logical indices 1..Length-1 in ascending order, one per granted cycle.
REQ-012 SCAN SHALL compare each returned MemRData against the latched head one cycle after the read, setting a sticky hit flag on match.
REQ-013 SCAN SHALL complete the full scan (no early exit) and enter DONE the cycle after the last comparison.
REQ-014 DONE SHALL assert StepDone for one cycle with StepHit = hit flag, clear the hit flag, and return to IDLE.
REQ-015 Port arbitration SHALL follow this fixed priority:
- InitValid write first.
- WRITE_HEAD write second.
- VgaReq third.
- Scan read last.
REQ-016 VgaGnt SHALL be combinational and high when VgaReq=1 and no higher-priority user holds the port.
REQ-017 Starvation guard: if VgaReq is granted for STARVE_LIMIT consecutive cycles while SCAN has a read pending, the next cycle SHALL grant the scan and hold VgaGnt low; the counter SHALL clear whenever the scan is granted or SCAN is not active.
REQ-018 A granted VGA read SHALL produce VgaValid exactly one cycle later.
REQ-019 VgaY/VgaX SHALL equal MemRData if VgaIndex<Length at grant time; otherwise they SHALL be 0,0 with no address dependence.
REQ-020 InitValid SHALL be honored in any state, aborting any in-flight step with no StepDone and discarding any pending VGA result:
- Set HeadPtr=0 and Length=1.
- Write {StepY,StepX} to address 0.
- Clear the hit flag and starvation counter.
- Go to IDLE.
REQ-021 Simultaneous InitValid and StepValid in IDLE SHALL perform the init only; the step SHALL not be accepted.
REQ-022 StepValid held while not ready SHALL be ignored until StepReady=1; no request queuing.

Reset
REQ-023 On ResetN low, asynchronously, the block SHALL enter IDLE and set the following:
- HeadPtr=0 and Length=1.
- StepReady=1.
- StepDone, StepHit, VgaGnt, VgaValid and MemWe = 0.
- VgaY, VgaX, MemAddr and MemWData = 0.
- Hit flag and starvation counter cleared.
REQ-024 RAM contents SHALL not be reset; a read of index 0 before the first init returns undefined data.

Verification
REQ-025 The bench SHALL cover Init(3,6), then step to (3,7) with StepGrow=0 -> MemWe once at address NUM_PIECES-1; Length=1; StepDone 2 cycles after accept with StepHit=0.
REQ-026 The bench SHALL cover growing to Length=4 along a straight line, then stepping back onto piece 2 -> StepHit=1; StepDone exactly 2+(Length-1)+1 cycles after accept.
REQ-027 The bench SHALL cover VgaReq held continuously during a 4-piece scan -> VgaGnt low on every 5th SCAN cycle; the scan completes; every grant yields VgaValid one cycle later.
REQ-028 The bench SHALL cover VgaIndex=Length with valid request -> VgaValid=1 next cycle with VgaY=0, VgaX=0.
REQ-029 The bench SHALL cover 40 grow-steps with NUM_PIECES=32 -> Length saturates at 32 and HeadPtr wraps; indices 0..31 read back the last 32 heads in reverse order.
REQ-030 The bench SHALL cover InitValid (and separately ResetN low) mid-SCAN -> no StepDone; Length=1; StepReady=1 next cycle.
